parity_frame_tx: RTL



---
 rtl/parity_frame_pkg.sv | 16 +
 rtl/parity_calc.sv | 14 +
 rtl/parity_frame_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and line levels for the even-parity serial frame transmitter.
package parity_frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Even parity generator: the output makes data plus parity hold an even count of ones.
module parity_calc #(
   parameter int unsigned DATA_W = 4
) (
   input  logic [DATA_W-1:0] data,
   output logic              parity
);

   // XOR reduction over the whole word
   always_comb begin
      parity = ^data;
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, even parity, stop bit.
module parity_frame_tx
   import parity_frame_pkg::*;
#(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t              state;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [BIT_W-1:0]    bit_idx;
   logic [DATA_W-1:0]   shift_reg;
   logic [DATA_W-1:0]   shift_next;
   logic                parity_reg;
   logic                parity_bit;
   logic                bit_end;
   logic                last_bit;

   parity_calc #(
      .DATA_W (DATA_W)
   ) u_parity_calc (
      .data   (data_in),
      .parity (parity_bit)
   );

   // Bit-period and data-bit boundary detection, plus the next shifted word
   always_comb begin
      bit_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
      last_bit   = (bit_idx == BIT_W'(DATA_W - 1));
      shift_next = shift_reg >> 1;
   end

   // Status outputs decode directly from the state register
   always_comb begin
      ready_out = (state == IDLE);
      busy      = (state != IDLE);
   end

   // Frame FSM; tx_out is loaded with the level of the state being entered so the
   // line is fully registered yet changes on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tx_out     <= LINE_IDLE;
         frame_done <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  shift_reg  <= data_in;
                  parity_reg <= parity_bit;
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  tx_out     <= START_BIT;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx_out   <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (last_bit) begin
                     tx_out <= parity_reg;
                     state  <= PARITY;
                  end else begin
                     shift_reg <= shift_next;
                     tx_out    <= shift_next[0];
                     bit_idx   <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx_out   <= STOP_BIT;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt   <= '0;
                  tx_out     <= LINE_IDLE;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx_out   <= LINE_IDLE;
               baud_cnt <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
